corr_seq: RTL and testbench

Parametrised sequential correlation coprocessor, successor to the fixed 16-tap/4-lag combinational correlator on the processor's memory-mapped slave bus. Software loads a template and a signal window, writes START, and polls or takes an interrupt. A single multiply-accumulate engine computes `NUM_LAGS` cross-correlation lags, one product per cycle, and holds them in result registers. Template length, lag count, sample width and accumulator width are all parameters.

---
 rtl/corr_pkg.sv | 29 ++
 rtl/corr_mac.sv | 55 +++++
 rtl/corr_seq.sv | 196 +++++++++++++++++++
 tb/tb_corr_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared definitions for the corr_seq correlation coprocessor: bus address
// map, CTRL/STATUS bit positions and the sequencer state encoding.
package corr_pkg;

  // Word-address bases of the slave register map
  localparam logic [7:0] TMPL_BASE   = 8'h00;
  localparam logic [7:0] SIG_BASE    = 8'h40;
  localparam logic [7:0] CTRL_ADDR   = 8'h80;
  localparam logic [7:0] STATUS_ADDR = 8'h81;
  localparam logic [7:0] RES_BASE    = 8'hC0;

  // CTRL bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_DONE_CLR = 1;
  localparam int CTRL_IRQ_EN   = 2;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;
  localparam int STAT_ERR  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/corr_mac.sv
// Single signed multiply-accumulate step for corr_seq. Purely combinational:
// the accumulator register lives in the parent.
// Build option: CORR_SAT_EN selects a saturating accumulator with overflow
// flag; without it the sum wraps modulo 2^ACC_W and ovf_o is tied low.
module corr_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic signed [DATA_W-1:0] sig_i,
  input  logic signed [DATA_W-1:0] tmpl_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [ACC_W-1:0]  acc_o,
  output logic                     ovf_o
);

  localparam int PROD_W = 2 * DATA_W;
  // One guard bit above the wider of product and accumulator so the exact
  // sum is always representable before wrapping or clamping.
  localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum;

  assign prod = sig_i * tmpl_i;
  assign sum  = SUM_W'(acc_i) + SUM_W'(prod);

`ifdef CORR_SAT_EN
  localparam logic signed [SUM_W-1:0] ACC_MAX =
    {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN =
    {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  // Clamp the exact sum into the signed ACC_W range and flag any clamp
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    acc_o = sum[ACC_W-1:0];
    ovf_o = 1'b0;
    if (sum > ACC_MAX) begin
      acc_o = ACC_MAX[ACC_W-1:0];
      ovf_o = 1'b1;
    end else if (sum < ACC_MIN) begin
      acc_o = ACC_MIN[ACC_W-1:0];
      ovf_o = 1'b1;
    end
  end
`else
  // Wrapping accumulator: the guard bits are intentionally discarded
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[SUM_W-1:ACC_W];
  assign acc_o         = sum[ACC_W-1:0];
  assign ovf_o         = 1'b0;
`endif

endmodule

// File: rtl/corr_seq.sv
// Sequential cross-correlation coprocessor on a simple memory-mapped slave
// bus. Software loads template and signal words, writes START, and the
// single MAC computes NUM_LAGS lags at one product per cycle.
// Build option: CORR_SAT_EN (saturating accumulator, see corr_mac).
module corr_seq
  import corr_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TMPL_LEN = 16,
  parameter int NUM_LAGS = 4,
  parameter int ACC_W    = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        irq
);

  localparam int SPW        = 32 / DATA_W;
  localparam int LANE_W     = $clog2(SPW);
  localparam int TMPL_WORDS = TMPL_LEN / SPW;
  localparam int SIG_LEN    = TMPL_LEN + NUM_LAGS - 1;
  localparam int SIG_WORDS  = (SIG_LEN + SPW - 1) / SPW;
  localparam int TW_AW      = (TMPL_WORDS > 1) ? $clog2(TMPL_WORDS) : 1;
  localparam int SW_AW      = (SIG_WORDS > 1) ? $clog2(SIG_WORDS) : 1;
  localparam int LAG_W      = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1;
  localparam int TAP_W      = $clog2(TMPL_LEN);
  localparam int IDX_W      = $clog2(SIG_LEN + 1);

  // Operand and result storage
  logic [31:0]             tmpl_q [TMPL_WORDS];
  logic [31:0]             sig_q  [SIG_WORDS];
  logic signed [ACC_W-1:0] res_q  [NUM_LAGS];

  // Sequencer state
  state_e                  state_q;
  logic [LAG_W-1:0]        lag_q;
  logic [TAP_W-1:0]        tap_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    busy_q, done_q, ovf_q, err_q, irq_en_q;

  // Bus decode
  logic [6:0] widx;
  logic       sel_tmpl, sel_sig, sel_res;
  logic       op_wr, ctrl_wr, start, done_clr;

  assign widx     = {1'b0, address[5:0]};
  assign sel_tmpl = (address[7:6] == TMPL_BASE[7:6]) && (widx < 7'(TMPL_WORDS));
  assign sel_sig  = (address[7:6] == SIG_BASE[7:6])  && (widx < 7'(SIG_WORDS));
  assign sel_res  = (address[7:6] == RES_BASE[7:6])  && (widx < 7'(NUM_LAGS));
  assign op_wr    = write && (sel_tmpl || sel_sig);
  assign ctrl_wr  = write && (address == CTRL_ADDR);
  assign start    = ctrl_wr && writedata[CTRL_START];
  assign done_clr = ctrl_wr && writedata[CTRL_DONE_CLR];

  // Operand fetch for the current lag/tap
  logic [IDX_W-1:0]         samp_idx;
  logic [31:0]              sig_word, tmpl_word;
  logic signed [DATA_W-1:0] sig_smp, tmpl_smp;
  logic signed [ACC_W-1:0]  mac_acc;
  logic                     mac_ovf;
  logic                     tap_last, lag_last;

  assign tap_last = (tap_q == TAP_W'(TMPL_LEN - 1));
  assign lag_last = (lag_q == LAG_W'(NUM_LAGS - 1));

  // Select sig[lag+tap] and tmpl[tap] out of the packed bus words
  always_comb begin
    samp_idx  = IDX_W'(lag_q) + IDX_W'(tap_q);
    sig_word  = sig_q[SW_AW'(samp_idx >> LANE_W)];
    tmpl_word = tmpl_q[TW_AW'(tap_q >> LANE_W)];
    sig_smp   = '0;
    tmpl_smp  = '0;
    for (int l = 0; l < SPW; l++) begin
      if (samp_idx[LANE_W-1:0] == LANE_W'(l)) sig_smp  = sig_word[l*DATA_W +: DATA_W];
      if (tap_q[LANE_W-1:0]    == LANE_W'(l)) tmpl_smp = tmpl_word[l*DATA_W +: DATA_W];
    end
  end

  corr_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .sig_i  (sig_smp),
    .tmpl_i (tmpl_smp),
    .acc_i  (acc_q),
    .acc_o  (mac_acc),
    .ovf_o  (mac_ovf)
  );

  // Operand register file; writes are dropped while a run is in progress
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: these arrays are reset because software may read them back and
    // a reset must leave every operand word at zero; it costs a reset on
    // each flop, which is acceptable at these sizes.
    if (!reset_n) begin
      for (int i = 0; i < TMPL_WORDS; i++) tmpl_q[i] <= '0;
      for (int i = 0; i < SIG_WORDS; i++)  sig_q[i]  <= '0;
    end else if (op_wr && (state_q != ST_RUN)) begin
      if (sel_tmpl) tmpl_q[TW_AW'(address[5:0])] <= writedata;
      if (sel_sig)  sig_q[SW_AW'(address[5:0])]  <= writedata;
    end
  end

  // Result registers: lag l is overwritten only when its last tap completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LAGS; i++) res_q[i] <= '0;
    end else if ((state_q == ST_RUN) && tap_last) begin
      res_q[lag_q] <= mac_acc;
    end
  end

  // Sequencer FSM with counters, accumulator and sticky status flags
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      lag_q    <= '0;
      tap_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN];
      case (state_q)
        ST_RUN: begin
          if (start || op_wr) err_q <= 1'b1;
          if (mac_ovf) ovf_q <= 1'b1;
          if (tap_last) begin
            acc_q <= '0;
            tap_q <= '0;
            if (lag_last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              lag_q <= lag_q + 1'b1;
            end
          end else begin
            acc_q <= mac_acc;
            tap_q <= tap_q + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE: START wins over DONE_CLR in the same write
          if (start) begin
            state_q <= ST_RUN;
            lag_q   <= '0;
            tap_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
          end else if (done_clr) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign irq = done_q & irq_en_q;

  // Combinational read mux; unmapped addresses and idle strobe read 0
  always_comb begin
    readdata = '0;
    if (read) begin
      if (sel_tmpl) begin
        readdata = tmpl_q[TW_AW'(address[5:0])];
      end else if (sel_sig) begin
        readdata = sig_q[SW_AW'(address[5:0])];
      end else if (sel_res) begin
        readdata = 32'(res_q[LAG_W'(address[5:0])]);
      end else if (address == CTRL_ADDR) begin
        readdata[CTRL_IRQ_EN] = irq_en_q;
      end else if (address == STATUS_ADDR) begin
        readdata[STAT_BUSY] = busy_q;
        readdata[STAT_DONE] = done_q;
        readdata[STAT_OVF]  = ovf_q;
        readdata[STAT_ERR]  = err_q;
      end
    end
  end

endmodule

// File: tb/tb_corr_seq.sv
// Self-checking bench for corr_seq: a 32-bit-accumulator instance and a
// 16-bit-accumulator instance share one bus. Reads go through a scoreboard.
module tb_corr_seq;
  import corr_pkg::*;

  localparam int TMPL_LEN   = 16;
  localparam int NUM_LAGS   = 4;
  localparam int SIG_LEN    = TMPL_LEN + NUM_LAGS - 1;
  localparam int TMPL_WORDS = TMPL_LEN / 4;
  localparam int SIG_WORDS  = (SIG_LEN + 3) / 4;
`ifdef CORR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata, readdata16;
  logic        irq, irq16;

  always #5 clk = ~clk;

  corr_seq #(.DATA_W(8), .TMPL_LEN(TMPL_LEN), .NUM_LAGS(NUM_LAGS), .ACC_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .readdata(readdata),
    .write(write), .writedata(writedata), .irq(irq));

  corr_seq #(.DATA_W(8), .TMPL_LEN(TMPL_LEN), .NUM_LAGS(NUM_LAGS), .ACC_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .readdata(readdata16),
    .write(write), .writedata(writedata), .irq(irq16));

  int checks = 0;
  int errors = 0;

  int tmpl_s [TMPL_LEN];
  int sig_s  [SIG_LEN];

  typedef struct {
    string       name;
    bit          use16;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [7:0]  addr;
    bit          use16;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is at a falling edge; the write is taken at the next rising edge
  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    address   = addr;
    writedata = data;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  // Expected value is queued as the read is issued, popped when sampled
  task automatic rd(input string name, input logic [7:0] addr, input bit use16,
                    input logic [31:0] exp);
    sb_t e;
    e.name  = name;
    e.use16 = use16;
    e.exp   = exp;
    address = addr;
    read    = 1'b1;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check(e.name, e.use16 ? readdata16 : readdata, e.exp);
    @(negedge clk);
    read = 1'b0;
  endtask

  // Poll STATUS once per cycle from cycle cyc0 until done or the budget ends
  task automatic wait_done(input int cyc0, input int budget, output int done_cyc,
                           output int busy_cyc, output int first_busy,
                           output bit irq_at_done, output bit irq_early);
    int cyc;
    logic [31:0] s;
    cyc = cyc0; done_cyc = -1; busy_cyc = 0; first_busy = -1;
    irq_at_done = 1'b0; irq_early = 1'b0;
    address = STATUS_ADDR;
    read    = 1'b1;
    while (cyc <= budget) begin
      #1;
      s = readdata;
      if (s[STAT_BUSY]) begin
        busy_cyc++;
        if (first_busy < 0) first_busy = cyc;
        if (irq) irq_early = 1'b1;
      end
      if (s[STAT_DONE]) begin
        done_cyc    = cyc;
        irq_at_done = irq;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    read = 1'b0;
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    logic [7:0] la, lb, lc, ld;
    la = 8'(a); lb = 8'(b); lc = 8'(c); ld = 8'(d);
    return {ld, lc, lb, la};
  endfunction

  // Write the bench's operand arrays into the DUT; absent lanes get 0xAA
  task automatic load_ops();
    int v [4];
    for (int w = 0; w < TMPL_WORDS; w++)
      wr(TMPL_BASE + 8'(w), pack4(tmpl_s[4*w], tmpl_s[4*w+1], tmpl_s[4*w+2], tmpl_s[4*w+3]));
    for (int w = 0; w < SIG_WORDS; w++) begin
      for (int j = 0; j < 4; j++) v[j] = (4*w + j < SIG_LEN) ? sig_s[4*w + j] : 'hAA;
      wr(SIG_BASE + 8'(w), pack4(v[0], v[1], v[2], v[3]));
    end
  endtask

  // Reference correlation with wrap or saturation at acc_w bits
  function automatic logic [31:0] model_res(input int l, input int acc_w, input bit sat);
    longint acc, lim;
    acc = 0;
    lim = longint'(1) <<< (acc_w - 1);
    for (int k = 0; k < TMPL_LEN; k++) begin
      acc += longint'(sig_s[l+k] * tmpl_s[k]);
      if (sat) begin
        if (acc > lim - 1) acc = lim - 1;
        else if (acc < -lim) acc = -lim;
      end else begin
        acc = acc & (2*lim - 1);
        if (acc >= lim) acc -= 2*lim;
      end
    end
    return acc[31:0];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int dc, bc, fb;
    bit ia, ie;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd("rst_status", STATUS_ADDR, 1'b0, 32'h0);
    rd("rst_ctrl",   CTRL_ADDR,   1'b0, 32'h0);
    rd("rst_res0",   RES_BASE,    1'b0, 32'h0);
    rd("rst_tmpl0",  TMPL_BASE,   1'b0, 32'h0);
    rd("unmapped",   8'h90,       1'b0, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // ---------------- scenario 1: ones * ramp ----------------
    for (int k = 0; k < TMPL_LEN; k++) tmpl_s[k] = 1;
    for (int i = 0; i < SIG_LEN; i++)  sig_s[i]  = i + 1;
    load_ops();
    rd("sig4_readback", SIG_BASE + 8'd4, 1'b0, 32'hAA131211);
    wr(CTRL_ADDR, 32'h1);
    wait_done(1, 300, dc, bc, fb, ia, ie);
    check("s1_done_cycle", 32'(dc), 32'd65);
    check("s1_busy_cycles", 32'(bc), 32'd64);
    check("s1_first_busy", 32'(fb), 32'd1);

    vecs[0] = '{"s1_res0", RES_BASE + 8'd0, 1'b0, 32'd136};
    vecs[1] = '{"s1_res1", RES_BASE + 8'd1, 1'b0, 32'd152};
    vecs[2] = '{"s1_res2", RES_BASE + 8'd2, 1'b0, 32'd168};
    vecs[3] = '{"s1_res3", RES_BASE + 8'd3, 1'b0, 32'd184};
    vecs[4] = '{"s1_res3_acc16", RES_BASE + 8'd3, 1'b1, 32'd184};
    vecs[5] = '{"s1_status", STATUS_ADDR, 1'b0, 32'h2};
    for (int i = 0; i < 6; i++) rd(vecs[i].name, vecs[i].addr, vecs[i].use16, vecs[i].exp);
    check("s1_irq_disabled", 32'(irq), 32'h0);
    wr(CTRL_ADDR, 32'h2);
    rd("s1_done_clr", STATUS_ADDR, 1'b0, 32'h0);

    // ---------------- scenario 2: illegal accesses mid-run ----------------
    wr(CTRL_ADDR, 32'h1);                       // cycle 0
    repeat (9) @(negedge clk);                  // now at cycle 10
    wr(TMPL_BASE, 32'h05050505);                // cycle 10
    repeat (9) @(negedge clk);                  // now at cycle 20
    wr(CTRL_ADDR, 32'h1);                       // cycle 20, ignored
    wait_done(21, 300, dc, bc, fb, ia, ie);
    check("s2_done_cycle", 32'(dc), 32'd65);
    rd("s2_status", STATUS_ADDR, 1'b0, 32'hA);
    rd("s2_tmpl0", TMPL_BASE, 1'b0, 32'h01010101);
    for (int i = 0; i < 4; i++) rd(vecs[i].name, vecs[i].addr, vecs[i].use16, vecs[i].exp);

    // ---------------- scenario 3: interrupt ----------------
    wr(CTRL_ADDR, 32'h6);                       // irq_en + DONE_CLR
    rd("s3_status_idle", STATUS_ADDR, 1'b0, 32'h8);
    rd("s3_ctrl", CTRL_ADDR, 1'b0, 32'h4);
    check("s3_irq_idle", 32'(irq), 32'h0);
    wr(CTRL_ADDR, 32'h5);
    wait_done(1, 300, dc, bc, fb, ia, ie);
    check("s3_done_cycle", 32'(dc), 32'd65);
    check("s3_irq_at_done", 32'(ia), 32'h1);
    check("s3_irq_early", 32'(ie), 32'h0);
    wr(CTRL_ADDR, 32'h7);                       // restart with DONE_CLR
    check("s3_irq_drop", 32'(irq), 32'h0);
    rd("s3_restart_status", STATUS_ADDR, 1'b0, 32'h1);
    wait_done(2, 300, dc, bc, fb, ia, ie);
    check("s3_rerun_done", 32'(dc), 32'd65);
    wr(CTRL_ADDR, 32'h2);

    // ---------------- scenario 4: -128 * -128 ----------------
    for (int k = 0; k < TMPL_LEN; k++) tmpl_s[k] = -128;
    for (int i = 0; i < SIG_LEN; i++)  sig_s[i]  = -128;
    load_ops();
    wr(CTRL_ADDR, 32'h1);
    wait_done(1, 300, dc, bc, fb, ia, ie);
    for (int l = 0; l < NUM_LAGS; l++) begin
      rd($sformatf("s4_res%0d", l), RES_BASE + 8'(l), 1'b0, model_res(l, 32, SAT));
      rd($sformatf("s4_res%0d_acc16", l), RES_BASE + 8'(l), 1'b1, model_res(l, 16, SAT));
    end
    rd("s4_status", STATUS_ADDR, 1'b0, 32'h2);
    rd("s4_status_acc16", STATUS_ADDR, 1'b1, SAT ? 32'h6 : 32'h2);

    // ---------------- scenario 5: reset mid-run ----------------
    wr(CTRL_ADDR, 32'h5);                       // cycle 0, irq_en set
    repeat (29) @(negedge clk);                 // now at cycle 30
    #2 reset_n = 1'b0;
    #1;
    check("s5_irq", 32'(irq), 32'h0);
    check("s5_irq_acc16", 32'(irq16), 32'h0);
    @(negedge clk);
    rd("s5_status", STATUS_ADDR, 1'b0, 32'h0);
    rd("s5_ctrl", CTRL_ADDR, 1'b0, 32'h0);
    for (int l = 0; l < NUM_LAGS; l++)
      rd($sformatf("s5_res%0d", l), RES_BASE + 8'(l), 1'b0, 32'h0);
    rd("s5_tmpl0", TMPL_BASE, 1'b0, 32'h0);
    rd("s5_tmpl3", TMPL_BASE + 8'd3, 1'b0, 32'h0);
    rd("s5_sig0", SIG_BASE, 1'b0, 32'h0);
    rd("s5_sig4", SIG_BASE + 8'd4, 1'b0, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    rd("s5_status_after", STATUS_ADDR, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
